// File: rtl/dwc_downsample.sv
// Wide-to-narrow stream converter: one IN_WIDTH word out as TOTAL_ITERS OUT_WIDTH beats, lowest slice first,
// first beat one cycle after accept; stalls hold the current beat, and a new word is taken only as the last beat leaves.
module dwc_downsample #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [IN_WIDTH-1:0]  s_axis_input_tdata,
  input  logic                 s_axis_input_tvalid,
  output logic                 s_axis_input_tready,
  output logic [OUT_WIDTH-1:0] m_axis_output_tdata,
  output logic                 m_axis_output_tvalid,
  input  logic                 m_axis_output_tready
);

  localparam int SAFE_OUT    = (OUT_WIDTH > 0) ? OUT_WIDTH : 1;
  localparam int TOTAL_ITERS = IN_WIDTH / SAFE_OUT;
  localparam int CW          = $clog2(TOTAL_ITERS + 1);

  if (OUT_WIDTH == 0 || (IN_WIDTH % SAFE_OUT) != 0) begin : g_bad_widths
    $error("dwc_downsample: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                in_rdy;
  logic                in_fire;
  logic                out_fire;

  // Refill is allowed while the final beat is leaving, which keeps back-to-back words bubble-free.
  assign in_rdy   = (cnt_q == '0) || ((cnt_q == CW'(1)) && m_axis_output_tready);
  assign in_fire  = s_axis_input_tvalid && in_rdy;
  assign out_fire = (cnt_q != '0) && m_axis_output_tready;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (in_fire) begin
      data_d = s_axis_input_tdata;
      cnt_d  = CW'(TOTAL_ITERS);
    end else if (out_fire) begin
      data_d = data_q >> OUT_WIDTH;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign s_axis_input_tready  = in_rdy;
  assign m_axis_output_tvalid = (cnt_q != '0);
  assign m_axis_output_tdata  = data_q[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_dwc_downsample.sv
// Directed bench for dwc_downsample (32->8) plus a randomized pass-through check of the 16->16 configuration.
module tb_dwc_downsample;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic [31:0] s_dat;
  logic        s_vld;
  logic        s_rdy;
  logic [7:0]  m_dat;
  logic        m_vld;
  logic        m_rdy;

  logic [15:0] d16;
  logic        v16;
  logic        s16_rdy;
  logic [15:0] m16_dat;
  logic        m16_vld;
  logic        r16;

  int vectors     = 0;
  int miscompares = 0;

  always #5 ap_clk = ~ap_clk;

  dwc_downsample #(.IN_WIDTH(32), .OUT_WIDTH(8)) u_dut (
    .ap_clk               (ap_clk),
    .ap_rst               (ap_rst),
    .s_axis_input_tdata   (s_dat),
    .s_axis_input_tvalid  (s_vld),
    .s_axis_input_tready  (s_rdy),
    .m_axis_output_tdata  (m_dat),
    .m_axis_output_tvalid (m_vld),
    .m_axis_output_tready (m_rdy)
  );

  dwc_downsample #(.IN_WIDTH(16), .OUT_WIDTH(16)) u_dut16 (
    .ap_clk               (ap_clk),
    .ap_rst               (ap_rst),
    .s_axis_input_tdata   (d16),
    .s_axis_input_tvalid  (v16),
    .s_axis_input_tready  (s16_rdy),
    .m_axis_output_tdata  (m16_dat),
    .m_axis_output_tvalid (m16_vld),
    .m_axis_output_tready (r16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  // Presented beat check: valid high, data as given, input ready as given.
  task automatic beat(input string tag, input logic [7:0] exp_dat, input logic exp_rdy);
    #1;
    chk({tag, "_vld"}, 32'(m_vld), 32'd1);
    chk({tag, "_dat"}, 32'(m_dat), 32'(exp_dat));
    chk({tag, "_srdy"}, 32'(s_rdy), 32'(exp_rdy));
  endtask

  task automatic idle(input string tag);
    #1;
    chk({tag, "_vld"}, 32'(m_vld), 32'd0);
    chk({tag, "_srdy"}, 32'(s_rdy), 32'd1);
  endtask

  logic [15:0] q16[$];
  logic        pend16;
  logic        in_f16, out_f16;

  initial begin
    s_dat = '0; s_vld = 1'b0; m_rdy = 1'b1;
    d16 = '0; v16 = 1'b0; r16 = 1'b1;

    // Reset state, observed while reset is still asserted.
    #1 ap_rst = 1'b1;
    #2;
    chk("rst_vld", 32'(m_vld), 32'd0);
    chk("rst_dat", 32'(m_dat), 32'd0);
    chk("rst_srdy", 32'(s_rdy), 32'd1);
    tick;
    ap_rst = 1'b0;
    idle("post_rst");

    // Single word, lowest byte first.
    tick;
    s_dat = 32'hDDCCBBAA; s_vld = 1'b1;
    tick;
    s_vld = 1'b0;
    beat("w1_b0", 8'hAA, 1'b0);
    tick; beat("w1_b1", 8'hBB, 1'b0);
    tick; beat("w1_b2", 8'hCC, 1'b0);
    tick; beat("w1_b3", 8'hDD, 1'b1);
    tick; idle("w1_done");

    // Back-to-back words with no bubble; second word taken alongside beat 0x44.
    s_dat = 32'h44332211; s_vld = 1'b1;
    tick;
    s_dat = 32'h88776655;
    beat("bb_11", 8'h11, 1'b0);
    tick; beat("bb_22", 8'h22, 1'b0);
    tick; beat("bb_33", 8'h33, 1'b0);
    tick; beat("bb_44", 8'h44, 1'b1);
    tick;
    s_vld = 1'b0;
    beat("bb_55", 8'h55, 1'b0);
    tick; beat("bb_66", 8'h66, 1'b0);
    tick; beat("bb_77", 8'h77, 1'b0);
    tick; beat("bb_88", 8'h88, 1'b1);
    tick; idle("bb_done");

    // Backpressure mid-word: 0xBB held for three stalled edges.
    s_dat = 32'hDDCCBBAA; s_vld = 1'b1;
    tick;
    s_vld = 1'b0;
    beat("bp_aa", 8'hAA, 1'b0);
    tick;
    m_rdy = 1'b0;
    beat("bp_bb", 8'hBB, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick; beat("bp_hold", 8'hBB, 1'b0);
    end
    m_rdy = 1'b1;
    tick; beat("bp_cc", 8'hCC, 1'b0);
    tick; beat("bp_dd", 8'hDD, 1'b1);
    tick; idle("bp_done");

    // Last-beat stall with a new word waiting.
    s_dat = 32'hDDCCBBAA; s_vld = 1'b1;
    tick;
    s_vld = 1'b0;
    beat("ls_aa", 8'hAA, 1'b0);
    tick; beat("ls_bb", 8'hBB, 1'b0);
    tick; beat("ls_cc", 8'hCC, 1'b0);
    tick;
    m_rdy = 1'b0;
    s_dat = 32'h11223344; s_vld = 1'b1;
    beat("ls_dd", 8'hDD, 1'b0);
    tick; beat("ls_dd_hold1", 8'hDD, 1'b0);
    tick; beat("ls_dd_hold2", 8'hDD, 1'b0);
    m_rdy = 1'b1;
    beat("ls_dd_go", 8'hDD, 1'b1);
    tick;
    s_vld = 1'b0;
    beat("ls_44", 8'h44, 1'b0);
    tick; beat("ls_33", 8'h33, 1'b0);
    tick; beat("ls_22", 8'h22, 1'b0);
    tick; beat("ls_11", 8'h11, 1'b1);
    tick; idle("ls_done");

    // Asynchronous reset between edges after two beats have left.
    s_dat = 32'hDDCCBBAA; s_vld = 1'b1;
    tick;
    s_vld = 1'b0;
    beat("ar_aa", 8'hAA, 1'b0);
    tick; beat("ar_bb", 8'hBB, 1'b0);
    tick; beat("ar_cc", 8'hCC, 1'b0);
    #1 ap_rst = 1'b1;
    #1;
    chk("ar_vld", 32'(m_vld), 32'd0);
    chk("ar_dat", 32'(m_dat), 32'd0);
    chk("ar_srdy", 32'(s_rdy), 32'd1);
    tick;
    ap_rst = 1'b0;
    s_dat = 32'h01020304; s_vld = 1'b1;
    tick;
    s_vld = 1'b0;
    beat("ar_04", 8'h04, 1'b0);
    tick; beat("ar_03", 8'h03, 1'b0);
    tick; beat("ar_02", 8'h02, 1'b0);
    tick; beat("ar_01", 8'h01, 1'b1);
    tick; idle("ar_done");

    // 16->16: single-stage register, random valid/ready, stream must pass unchanged.
    pend16 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c >= 360) begin
        v16 = 1'b0;
        r16 = 1'b1;
      end else begin
        if (!pend16) begin
          v16 = 1'($urandom_range(0, 1));
          d16 = 16'($urandom);
        end
        r16 = 1'($urandom_range(0, 3) != 0);
      end
      #1;
      chk("dw16_rdy", 32'(s16_rdy), 32'(!m16_vld || r16));
      in_f16  = v16 && s16_rdy;
      out_f16 = m16_vld && r16;
      if (out_f16) begin
        chk("dw16_has_word", 32'(q16.size() != 0), 32'd1);
        if (q16.size() != 0) chk("dw16_dat", 32'(m16_dat), 32'(q16.pop_front()));
      end
      if (in_f16) q16.push_back(d16);
      pend16 = v16 && !s16_rdy;
      tick;
    end
    #1;
    chk("dw16_drained", 32'(q16.size()), 32'd0);
    chk("dw16_idle_vld", 32'(m16_vld), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
